// File: rtl/dm_access_pkg.sv
// Shared types and widths for the data-memory access stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dm_access_pkg;

    localparam int DM_ADDR_W = 16;
    localparam int DM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/dm_access_if.sv
// Request/response handshake between the pipeline and the memory-access stage.
// Latency: n/a (wires only).
// Backpressure: req_ready / resp_ready valid-ready pairs.
interface dm_access_if;
    import dm_access_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [DM_ADDR_W-1:0] req_addr;
    logic [DM_DATA_W-1:0] req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DM_DATA_W-1:0] resp_rdata;
    logic                 resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dm_access_sat_ctr.sv
// Saturating event counter; sticks at all-ones.
// Latency: count visible the cycle after inc.
// Backpressure: none.
module dm_access_sat_ctr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dm_access_unit.sv
// Single-outstanding load/store stage in front of the data memory, with debug counters.
// Latency: accept edge -> one ACCESS cycle -> resp_valid on the following cycle.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
module dm_access_unit
    import dm_access_pkg::*;
#(
    parameter int DM_DEPTH = 256,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dm_access_if.slave           bus,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic                 dm_wen,
    output logic [DM_DATA_W-1:0] dm_wdata,
    input  logic [DM_DATA_W-1:0] dm_rdata,
    output logic [CNT_W-1:0]     load_cnt,
    output logic [CNT_W-1:0]     store_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam logic [DM_ADDR_W:0] DEPTH_L = (DM_ADDR_W + 1)'(DM_DEPTH);

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [DM_ADDR_W-1:0] addr_q, addr_d;
    logic [DM_DATA_W-1:0] wdata_q, wdata_d;
    logic [DM_DATA_W-1:0] rdata_q, rdata_d;
    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_err_q, resp_err_d;
    logic                 req_err;
    logic                 resp_hs;

    assign req_err = bus.req_addr[0] | ({1'b0, bus.req_addr} >= DEPTH_L);
    assign resp_hs = resp_valid_q & bus.resp_ready;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    err_d   = req_err;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Only good loads return data; stores and errors report zero.
                rdata_d    = (!we_q && !err_q) ? dm_rdata : '0;
                resp_err_d = err_q;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = resp_err_q;

    // Write enable is gated by rst directly so a reset landing in ACCESS cancels the store.
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;
    assign dm_wen   = (state_q == ACCESS) & we_q & ~err_q & ~rst;

    dm_access_sat_ctr #(.CNT_W(CNT_W)) u_load_ctr (
        .clk (clk),
        .rst (rst),
        .inc (resp_hs & ~we_q & ~err_q),
        .cnt (load_cnt)
    );

    dm_access_sat_ctr #(.CNT_W(CNT_W)) u_store_ctr (
        .clk (clk),
        .rst (rst),
        .inc (resp_hs & we_q & ~err_q),
        .cnt (store_cnt)
    );

    dm_access_sat_ctr #(.CNT_W(CNT_W)) u_err_ctr (
        .clk (clk),
        .rst (rst),
        .inc (resp_hs & err_q),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: transaction-level reference model plus directed literal checks.
module tb_dm_access_unit;

    logic        clk;
    logic        rst;
    logic [15:0] dm_addr;
    logic        dm_wen;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;
    logic [15:0] err_cnt;

    dm_access_if bus ();

    dm_access_unit #(.DM_DEPTH(256), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dm_addr   (dm_addr),
        .dm_wen    (dm_wen),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment memory seen by the DUT, and the model's own view of memory contents.
    logic [15:0] dm_mem    [256];
    logic [15:0] model_mem [256];

    assign dm_rdata = dm_mem[dm_addr[7:0]];
    always @(posedge clk) if (dm_wen) dm_mem[dm_addr[7:0]] <= dm_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, ACCESS for one cycle, then RESP until taken.
    int unsigned edge_n   = 0;
    int unsigned acc_edge = 0;
    bit          pending  = 0;
    bit          p_we, p_err;
    logic [15:0] p_addr, p_wdata, p_rdata;
    logic [15:0] m_load = 0, m_store = 0, m_err = 0;
    int          wen_cnt = 0;
    bit          chk_en  = 0;
    bit          forcing = 0;

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (dm_wen === 1'b1) wen_cnt++;
        if (rst) begin
            pending = 0;
            m_load  = 0;
            m_store = 0;
            m_err   = 0;
        end else if (!pending) begin
            if (bus.req_valid) begin
                pending  = 1;
                acc_edge = edge_n;
                p_we     = bus.req_we;
                p_addr   = bus.req_addr;
                p_wdata  = bus.req_wdata;
                p_err    = (p_addr % 2 != 0) || (p_addr >= 256);
            end
        end else if (edge_n == acc_edge + 1) begin
            if (!p_err && p_we) model_mem[p_addr[7:0]] = p_wdata;
            p_rdata = (!p_err && !p_we) ? model_mem[p_addr[7:0]] : 16'h0;
        end else if (bus.resp_ready) begin
            if (p_err) begin
                if (m_err != 16'hFFFF) m_err++;
            end else if (p_we) begin
                if (m_store != 16'hFFFF) m_store++;
            end else begin
                if (m_load != 16'hFFFF) m_load++;
            end
            pending = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !forcing) begin
            automatic bit in_access = pending && (edge_n == acc_edge);
            automatic bit exp_rv    = pending && (edge_n >= acc_edge + 1);
            automatic bit exp_wen   = in_access && p_we && !p_err && !rst;
            chk("req_ready", bus.req_ready, !pending);
            chk("resp_valid", bus.resp_valid, exp_rv);
            if (exp_rv) begin
                chk("resp_rdata", bus.resp_rdata, p_rdata);
                chk("resp_err", bus.resp_err, p_err);
            end
            chk("dm_wen", dm_wen, exp_wen);
            if (in_access && !rst) begin
                chk("dm_addr", dm_addr, p_addr);
                chk("dm_wdata", dm_wdata, p_wdata);
            end
            chk("load_cnt", load_cnt, m_load);
            chk("store_cnt", store_cnt, m_store);
            chk("err_cnt", err_cnt, m_err);
        end
    end

    // Drives one request and collects its response; entered and left at posedge+1.
    task automatic xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int stall, output logic [15:0] rd, output logic er, output int lat);
        int n;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = 1'b0;
        rd  = 16'h0;
        er  = 1'b0;
        lat = 0;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
        lat = 1;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; lat++; n++;
        end
        chk("resp_arrives", bus.resp_valid, 1'b1);
        rd = bus.resp_rdata;
        er = bus.resp_err;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;
        int          w0;

        for (int i = 0; i < 256; i++) begin
            dm_mem[i]    = 16'h0;
            model_mem[i] = 16'h0;
        end
        dm_mem[0] = 16'd100; dm_mem[2] = 16'd43; dm_mem[4] = 16'd6;
        dm_mem[6] = 16'd58;  dm_mem[8] = 16'd77;
        model_mem[0] = 16'd100; model_mem[2] = 16'd43; model_mem[4] = 16'd6;
        model_mem[6] = 16'd58;  model_mem[8] = 16'd77;

        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 16'h0;
        bus.req_wdata  = 16'h0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_rdata", bus.resp_rdata, 16'h0);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_dm_addr", dm_addr, 16'h0);
        chk("rst_dm_wdata", dm_wdata, 16'h0);
        chk("rst_dm_wen", dm_wen, 1'b0);
        chk("rst_load_cnt", load_cnt, 16'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Basic load and its latency
        xact(1'b0, 16'h0002, 16'h0, 0, rd, er, lat);
        chk("ld2_rdata", rd, 16'd43);
        chk("ld2_err", er, 1'b0);
        chk("ld2_latency", lat, 2);
        chk("ld2_load_cnt", load_cnt, 16'd1);

        // Store then read back; exactly one write strobe
        w0 = wen_cnt;
        xact(1'b1, 16'h0006, 16'h1234, 0, rd, er, lat);
        chk("st6_wen_cycles", wen_cnt - w0, 1);
        chk("st6_rdata", rd, 16'h0);
        xact(1'b0, 16'h0006, 16'h0, 1, rd, er, lat);
        chk("ld6_rdata", rd, 16'h1234);
        chk("st6_store_cnt", store_cnt, 16'd1);

        // Misaligned load and out-of-range store
        w0 = wen_cnt;
        xact(1'b0, 16'h0003, 16'h0, 0, rd, er, lat);
        chk("ld3_err", er, 1'b1);
        chk("ld3_rdata", rd, 16'h0);
        xact(1'b1, 16'h0100, 16'hAAAA, 0, rd, er, lat);
        chk("st100_err", er, 1'b1);
        chk("err_wen_cycles", wen_cnt - w0, 0);
        chk("err_cnt_two", err_cnt, 16'd2);

        // Response held under backpressure
        xact(1'b0, 16'h0008, 16'h0, 3, rd, er, lat);
        chk("ld8_rdata", rd, 16'd77);
        chk("ld8_load_cnt", load_cnt, 16'd3);

        // Reset during ACCESS of a store drops it
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0004;
        bus.req_wdata = 16'hBEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("drop_resp_valid", bus.resp_valid, 1'b0);
        chk("drop_store_cnt", store_cnt, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        xact(1'b0, 16'h0004, 16'h0, 0, rd, er, lat);
        chk("ld4_after_drop", rd, 16'd6);
        chk("dm4_untouched", dm_mem[4], 16'd6);

        // Randomized mix of good, misaligned and out-of-range accesses
        for (int t = 0; t < 60; t++) begin
            automatic int          kind = int'($urandom_range(0, 5));
            automatic logic [15:0] a;
            if (kind <= 3)      a = {8'h00, 7'($urandom), 1'b0};
            else if (kind == 4) a = {8'h00, 7'($urandom), 1'b1};
            else                a = 16'($urandom) | 16'h0100;
            xact(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 3)), rd, er, lat);
            chk("rand_latency", lat, 2);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Saturation: preset the load counter near the top
        forcing = 1'b1;
        force dut.u_load_ctr.cnt_q = 16'hFFFE;
        m_load = 16'hFFFE;
        @(posedge clk); #1;
        release dut.u_load_ctr.cnt_q;
        forcing = 1'b0;
        xact(1'b0, 16'h0000, 16'h0, 0, rd, er, lat);
        chk("sat_first", load_cnt, 16'hFFFF);
        xact(1'b0, 16'h0002, 16'h0, 0, rd, er, lat);
        chk("sat_stick", load_cnt, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
